multdiv_unit: RTL and testbench

Iterative 32-bit signed multiply/divide unit serving the execute stage of the 5-stage pipelined processor. The execute stage pulses a command with both ALU operands; the unit produces the result and an exception flag several cycles later. Multiply and divide share one datapath, controlled by a small FSM and an iteration counter. The execute stage stalls on `busy` and writes back on `data_resultRDY`.

---
 rtl/multdiv_pkg.sv | 16 +
 rtl/multdiv_if.sv | 39 +++
 rtl/addsub_nbit.sv | 16 +
 rtl/multdiv_unit.sv | 160 ++++++++++++++++
 tb/tb_multdiv_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/multdiv_if.sv
// Command/result bundle between the execute stage and multdiv_unit.
interface multdiv_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/addsub_nbit.sv
// N-bit adder/subtractor shared by the multiply add and divide trial subtract.
module addsub_nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  logic [N-1:0] b_x;

  assign b_x = sub ? ~b : b;
  assign y   = a + b_x + N'(sub);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide, one bit per cycle.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               div_q, div_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a = bus.data_operandA[WIDTH-1];
  assign sign_b = bus.data_operandB[WIDTH-1];
  assign mag_a  = sign_a ? (~bus.data_operandA + WIDTH'(1))
                         : bus.data_operandA;
  assign mag_b  = sign_b ? (~bus.data_operandB + WIDTH'(1))
                         : bus.data_operandB;

  // acc: MUL = {partial product, multiplier}; DIV = {remainder, quotient}
  logic [WIDTH:0] shl, add_a, add_b, add_y;
  logic           add_sub;

  assign shl     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign add_sub = (state_q == DIV);
  assign add_a   = add_sub ? shl : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign add_b   = {1'b0, opnd_q};

  addsub_nbit #(.N(WIDTH+1)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .y   (add_y)
  );

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;

  assign prod = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  assign quo  = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1))
                      : acc_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    div_d   = div_q;
    dz_d    = dz_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        dz_d  = 1'b0;
        neg_d = sign_a ^ sign_b;
        if (bus.ctrl_MULT) begin
          state_d = MUL;
          div_d   = 1'b0;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          opnd_d  = mag_a;
          busy_d  = 1'b1;
        end else if (bus.ctrl_DIV) begin
          div_d  = 1'b1;
          acc_d  = {{WIDTH{1'b0}}, mag_a};
          opnd_d = mag_b;
          if (bus.data_operandB == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
            busy_d  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d = acc_q[0] ? {add_y, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      end
      DIV: begin
        // negative trial difference means restore the shifted remainder
        acc_d = add_y[WIDTH]
              ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
              : {add_y[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        if (dz_q) begin
          res_d = '0;
          exc_d = 1'b1;
        end else if (div_q) begin
          res_d = quo;
          exc_d = ~neg_q & acc_q[WIDTH-1];
        end else begin
          res_d = prod[WIDTH-1:0];
          exc_d = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized bench for multdiv_unit against a plain-arithmetic model.
module tb_multdiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  multdiv_if #(.WIDTH(W)) bus ();

  multdiv_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input bit is_mul,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic e);
    longint p;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  task automatic start(input bit is_mul,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT = is_mul;
    bus.ctrl_DIV = !is_mul;
    @(posedge clk);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
  endtask

  // n0: edges already seen since the command edge
  task automatic finish_op(input string tag,
                           input bit is_mul,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input int n0);
    logic [31:0] er;
    logic ee;
    int n;
    int lat;
    model(is_mul, a, b, er, ee);
    lat = (!is_mul && b == 32'd0) ? 1 : 33;
    n = n0;
    if (n0 == 0) chk({tag, " busy"}, 32'(bus.busy), 32'(lat != 1));
    while (!bus.data_resultRDY && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " res"}, bus.data_result, er);
    chk({tag, " exc"}, 32'(bus.data_exception), 32'(ee));
    chk({tag, " busy@rdy"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'(signed'($urandom_range(0, 200)) - 100);
      4: return 32'(signed'($urandom_range(0, 131070)) - 65535);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    #1;
    chk("rst res", bus.data_result, 32'd0);
    chk("rst exc", 32'(bus.data_exception), 32'd0);
    chk("rst rdy", 32'(bus.data_resultRDY), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start(1'b1, 32'd6, 32'd7);
    finish_op("6x7", 1'b1, 32'd6, 32'd7, 0);
    start(1'b1, -32'sd5, 32'd3);
    finish_op("-5x3", 1'b1, -32'sd5, 32'd3, 0);
    start(1'b1, 32'h0001_0000, 32'h0001_0000);
    finish_op("ovf mul", 1'b1, 32'h0001_0000, 32'h0001_0000, 0);
    start(1'b0, 32'd100, -32'sd7);
    finish_op("100/-7", 1'b0, 32'd100, -32'sd7, 0);
    start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    start(1'b0, 32'd123, 32'd0);
    finish_op("123/0", 1'b0, 32'd123, 32'd0, 0);

    // divide command mid-multiply must be dropped
    start(1'b1, 32'h1234, 32'h5678);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd0;
    bus.ctrl_DIV = 1'b1;
    @(posedge clk);
    #1;
    bus.ctrl_DIV = 1'b0;
    finish_op("busy cmd", 1'b1, 32'h1234, 32'h5678, 5);
    start(1'b0, -32'sd1000, 32'd33);
    finish_op("b2b", 1'b0, -32'sd1000, 32'd33, 0);

    // asynchronous abort mid-multiply
    start(1'b1, 32'd7, 32'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort res", bus.data_result, 32'd0);
    chk("abort exc", 32'(bus.data_exception), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (bus.data_resultRDY) seen = 1'b1;
    end
    chk("abort rdy", 32'(seen), 32'd0);
    start(1'b1, 32'd2, 32'd3);
    finish_op("2x3", 1'b1, 32'd2, 32'd3, 0);

    for (int k = 0; k < 30; k++) begin
      bit m;
      logic [31:0] a, b;
      m = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      start(m, a, b);
      finish_op(m ? "rnd mul" : "rnd div", m, a, b, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
